led_scan_decoder: RTL and testbench

- Receive-side counterpart of the 7-segment encoder path.
- Samples a multiplexed common-anode display bus (active-low segments abcdefgp, a = bit 0; active-low digit selects).
- Debounces each scan slot and decodes the segment pattern back to a 4-bit hex value plus dot.
- Keeps a per-digit register image of what is on the display; used for display self-test and loopback checking.

---
 rtl/led_scan_decoder_pkg.sv | 25 ++
 rtl/led_scan_decoder_seg.sv | 24 ++
 rtl/led_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_led_scan_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_scan_decoder_pkg.sv
// Shared 7-segment glyph table (active-low, bit 0 = segment a) and capture classification.
// The encoder path and led_scan_decoder must both draw their glyphs from this one table.
package led_scan_decoder_pkg;

  // A segment is lit when its line is driven low.
  localparam logic SEG_LIT = 1'b0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Element [n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [2:0] {
    CAP_NONE,
    CAP_IDLE,
    CAP_MULTI,
    CAP_GLYPH,
    CAP_BLANK,
    CAP_ILLEGAL
  } cap_kind_e;

endpackage

// File: rtl/led_scan_decoder_seg.sv
// Combinational reverse lookup of an active-low 7-segment pattern into a hex value.
module seg_pattern_decoder
  import led_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] value
);

  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPHS[i]) begin
        hit   = 1'b1;
        value = 4'(i);
      end
    end
  end

  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/led_scan_decoder.sv
// Samples a multiplexed common-anode display bus, debounces each scan slot and keeps
// a per-digit image of the decoded value, dot, legality and blank state.
module led_scan_decoder
  import led_scan_decoder_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel_n,
  output logic [4*DIGITS-1:0]   digit_bcd,
  output logic [DIGITS-1:0]     digit_dot,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  frame_done,
  output logic                  decode_err
);

  localparam int W  = DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [W-1:0]      s1, s2, prev;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] seen;

  logic [DIGITS-1:0] sel_low;
  logic [7:0]        seg_s;
  logic              capture;
  logic              dec_hit, dec_blank;
  logic [3:0]        dec_value;
  cap_kind_e         kind;

  logic [4*DIGITS-1:0] bcd_n;
  logic [DIGITS-1:0]   dot_n, valid_n, blank_n, seen_n, seen_tmp;
  logic                done_n, err_n;

  assign sel_low = ~s2[W-1:8];
  assign seg_s   = s2[7:0];

  // Fires on the single cycle the counter passes STABLE_CYCLES-1, so a held slot captures once.
  assign capture = (s2 == prev) && (cnt == CW'(STABLE_CYCLES - 1));

  seg_pattern_decoder u_seg (
    .seg   (seg_s[6:0]),
    .hit   (dec_hit),
    .blank (dec_blank),
    .value (dec_value)
  );

  always_comb begin
    kind = CAP_NONE;
    if (capture) begin
      if (sel_low == '0)
        kind = CAP_IDLE;
      else if ((sel_low & (sel_low - DIGITS'(1))) != '0)
        kind = CAP_MULTI;
      else if (dec_hit)
        kind = CAP_GLYPH;
      else if (dec_blank)
        kind = CAP_BLANK;
      else
        kind = CAP_ILLEGAL;
    end
  end

  always_comb begin
    bcd_n    = digit_bcd;
    dot_n    = digit_dot;
    valid_n  = digit_valid;
    blank_n  = digit_blank;
    seen_n   = seen;
    seen_tmp = seen | sel_low;
    done_n   = 1'b0;
    err_n    = 1'b0;

    case (kind)
      CAP_MULTI: err_n = 1'b1;
      CAP_GLYPH, CAP_BLANK, CAP_ILLEGAL: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (sel_low[i]) begin
            dot_n[i] = (seg_s[7] == SEG_LIT);
            case (kind)
              CAP_GLYPH: begin
                bcd_n[4*i +: 4] = dec_value;
                valid_n[i]      = 1'b1;
                blank_n[i]      = 1'b0;
              end
              CAP_BLANK: begin
                valid_n[i] = 1'b0;
                blank_n[i] = 1'b1;
              end
              default: begin
                valid_n[i] = 1'b0;
                blank_n[i] = 1'b0;
              end
            endcase
          end
        end
        err_n = (kind == CAP_ILLEGAL);
        // The completing capture starts the next frame with an empty mask.
        if (&seen_tmp) begin
          done_n = 1'b1;
          seen_n = '0;
        end else begin
          seen_n = seen_tmp;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '1;
      s2          <= '1;
      prev        <= '1;
      cnt         <= '0;
      seen        <= '0;
      digit_bcd   <= '0;
      digit_dot   <= '0;
      digit_valid <= '0;
      digit_blank <= '1;
      frame_done  <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      s1   <= {dig_sel_n, seg_in};
      s2   <= s1;
      prev <= s2;
      if (s2 != prev)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + CW'(1);
      seen        <= seen_n;
      digit_bcd   <= bcd_n;
      digit_dot   <= dot_n;
      digit_valid <= valid_n;
      digit_blank <= blank_n;
      frame_done  <= done_n;
      decode_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_led_scan_decoder.sv
// Scoreboard bench for led_scan_decoder: stimulus queues expected output events,
// a negedge monitor pops and compares each time the outputs change or pulse.
module tb_led_scan_decoder;

  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  dot;
    logic [7:0]  valid;
    logic [7:0]  blank;
    logic        done;
    logic        err;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
    string name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [7:0]  dig_sel_n;
  logic [31:0] digit_bcd;
  logic [7:0]  digit_dot, digit_valid, digit_blank;
  logic        frame_done, decode_err;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  q[$];
  snap_t last;

  led_scan_decoder #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel_n   (dig_sel_n),
    .digit_bcd   (digit_bcd),
    .digit_dot   (digit_dot),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .frame_done  (frame_done),
    .decode_err  (decode_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mk(logic [31:0] b, logic [7:0] d, logic [7:0] v,
                               logic [7:0] k, logic dn, logic er);
    return '{bcd: b, dot: d, valid: v, blank: k, done: dn, err: er};
  endfunction

  function automatic snap_t cur_snap();
    return '{bcd: digit_bcd, dot: digit_dot, valid: digit_valid,
             blank: digit_blank, done: frame_done, err: decode_err};
  endfunction

  task automatic check(string name, snap_t got, snap_t exp, int gc, int ec);
    checks++;
    if (got !== exp || gc != ec) begin
      errors++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
               name, got, gc, exp, ec);
    end
  endtask

  always @(negedge clk) begin
    snap_t c;
    exp_t  e;
    c = cur_snap();
    if (!rst) begin
      if (c.done || c.err ||
          {c.bcd, c.dot, c.valid, c.blank} !== {last.bcd, last.dot, last.valid, last.blank}) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %h at cycle %0d, expected no change", c, cyc);
        end else begin
          e = q.pop_front();
          check(e.name, c, e.s, cyc, e.cyc);
        end
      end
    end
    last = c;
  end

  // Caller is at posedge+1; a pin change here is registered on the next edge and
  // its capture lands six edges after that.
  task automatic slot(logic [7:0] sel, logic [7:0] seg, int n, bit ev, snap_t s, string name);
    dig_sel_n = sel;
    seg_in    = seg;
    if (ev) q.push_back('{s: s, cyc: cyc + 7, name: name});
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [6:0]  glyph [8];
  logic [31:0] scan_bcd [8];
  logic [7:0]  scan_valid [8];
  logic [7:0]  scan_blank [8];
  snap_t       rst_snap;
  snap_t       none;

  initial begin
    glyph      = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    scan_bcd   = '{32'h00000000, 32'h00000010, 32'h00000210, 32'h00003210,
                   32'h00043210, 32'h00543210, 32'h06543210, 32'h76543210};
    scan_valid = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    scan_blank = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    rst_snap   = mk(32'h0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    none       = rst_snap;

    rst = 1'b1;
    dig_sel_n = 8'hFF;
    seg_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", cur_snap(), rst_snap, 0, 0);
    rst = 1'b0;

    slot(8'hFF, 8'hFF, 20, 0, none, "");
    slot(8'hFE, 8'h24, 10, 1, mk(32'h2, 8'h01, 8'h01, 8'hFE, 1'b0, 1'b0), "glyph2_d0");
    slot(8'hFF, 8'hFF, 8, 0, none, "");
    slot(8'hFD, 8'h79, 3, 0, none, "");
    slot(8'hFF, 8'hFF, 10, 0, none, "");
    slot(8'hFE, 8'hFE, 8, 1, mk(32'h2, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b1), "illegal_d0");
    slot(8'hFF, 8'hFF, 8, 0, none, "");
    slot(8'hFC, 8'hC0, 8, 1, mk(32'h2, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b1), "multi_select");
    slot(8'hFF, 8'hFF, 8, 0, none, "");

    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] sel;
        sel = ~(8'h01 << i);
        slot(sel, {1'b1, glyph[i]}, 8, (rep == 0) || (i == 7),
             mk(scan_bcd[i], 8'h00, scan_valid[i], scan_blank[i], i == 7, 1'b0),
             $sformatf("scan%0d_d%0d", rep, i));
      end
    end

    slot(8'hF7, 8'hFF, 8, 1, mk(32'h76543210, 8'h00, 8'hF7, 8'h08, 1'b0, 1'b0), "blank_d3");
    slot(8'hEF, 8'h19, 8, 1, mk(32'h76543210, 8'h10, 8'hF7, 8'h08, 1'b0, 1'b0), "dot_d4");

    // Partial frame: digits 0..6 seen, then reset before digit 7 is captured.
    slot(8'hFE, {1'b1, glyph[0]}, 8, 0, none, "");
    slot(8'hFD, {1'b1, glyph[1]}, 8, 0, none, "");
    slot(8'hFB, {1'b1, glyph[2]}, 8, 0, none, "");
    slot(8'hDF, {1'b1, glyph[5]}, 8, 0, none, "");
    slot(8'hBF, {1'b1, glyph[6]}, 8, 0, none, "");
    dig_sel_n = 8'h7F;
    seg_in = {1'b1, glyph[7]};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_scan", cur_snap(), rst_snap, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back('{s: mk(32'h70000000, 8'h00, 8'h80, 8'h7F, 1'b0, 1'b0), cyc: cyc + 7,
                  name: "after_reset_d7"});
    repeat (10) @(posedge clk);
    #1;
    slot(8'hFF, 8'hFF, 10, 0, none, "");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
